// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse-cipher core.
// S-box values are derived from the field inverse and affine map rather than tables.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEXP = 3'd1,
        INIT = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } aesState_e;

    function automatic int unsigned nrOf(input int unsigned keyBits);
        return (keyBits == 256) ? 14 : 10;
    endfunction

    function automatic logic [7:0] rconOf(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gfMul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gfMul2(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gfMul9(input logic [7:0] a);
        return gfMul2(gfMul2(gfMul2(a))) ^ a;
    endfunction

    function automatic logic [7:0] gfMul11(input logic [7:0] a);
        return gfMul2(gfMul2(gfMul2(a))) ^ gfMul2(a) ^ a;
    endfunction

    function automatic logic [7:0] gfMul13(input logic [7:0] a);
        return gfMul2(gfMul2(gfMul2(a))) ^ gfMul2(gfMul2(a)) ^ a;
    endfunction

    function automatic logic [7:0] gfMul14(input logic [7:0] a);
        return gfMul2(gfMul2(gfMul2(a))) ^ gfMul2(gfMul2(a)) ^ gfMul2(a);
    endfunction

    // a^254 is the multiplicative inverse, with 0 mapping to 0
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h01;
        b = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gfMul(r, b);
            b = gfMul(b, b);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gfInv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] a);
        return gfInv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; finalRound drops InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] stateIn,
    input  logic [127:0] roundKey,
    input  logic         finalRound,
    output logic [127:0] stateOut
);

    logic [127:0] shifted;
    logic [127:0] keyed;
    logic [127:0] mixed;
    logic [7:0]   a0, a1, a2, a3;

    always_comb begin
        shifted = '0;
        mixed   = '0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        // byte (row r, col c) lives at index 4c+r, MSB first
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = invSbox(stateIn[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        keyed = shifted ^ roundKey;
        for (int c = 0; c < 4; c++) begin
            a0 = keyed[127-32*c -: 8];
            a1 = keyed[119-32*c -: 8];
            a2 = keyed[111-32*c -: 8];
            a3 = keyed[103-32*c -: 8];
            mixed[127-32*c -: 32] = {
                gfMul14(a0) ^ gfMul11(a1) ^ gfMul13(a2) ^ gfMul9(a3),
                gfMul9(a0)  ^ gfMul14(a1) ^ gfMul11(a2) ^ gfMul13(a3),
                gfMul13(a0) ^ gfMul9(a1)  ^ gfMul14(a2) ^ gfMul11(a3),
                gfMul11(a0) ^ gfMul13(a1) ^ gfMul9(a2)  ^ gfMul14(a3)};
        end
        stateOut = finalRound ? keyed : mixed;
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/256 decrypt core: key table expansion, UNROLL rounds per clock,
// optional CBC chaining, one block in flight.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128,
    parameter int unsigned UNROLL   = 1,
    parameter int unsigned CBC_EN   = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                iv_load,
    input  logic [127:0]        iv_in,
    input  logic                cbc_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out,
    output logic                key_loaded
);

    localparam int unsigned NR    = nrOf(KEY_BITS);
    localparam int unsigned IDX_W = 4;

    aesState_e        stateQ, stateD;
    logic [127:0]     rkTable [NR+1];
    logic [IDX_W-1:0] kIdx, rnd, rconIdx;
    logic [127:0]     lastRk, last2Rk, blk, cSaved, chain, key0, key1, newRk, base;
    logic [31:0]      w3, subIn, subOut, temp, n0, n1, n2, n3;
    logic             oddStep, cbcFlag, keyLoadedQ, keyLoadedD, inRdyQ, keyAcc, dataAcc;
    logic [127:0]     stage [UNROLL+1];

    assign key0       = key_in[KEY_BITS-1 -: 128];
    assign key1       = (KEY_BITS == 256) ? key_in[127:0] : '0;
    assign in_ready   = inRdyQ & ~key_valid;  // a pending key load takes priority
    assign key_loaded = keyLoadedQ;
    assign keyAcc     = key_valid & key_ready;
    assign dataAcc    = in_valid & in_ready;

    // One 128-bit round key per cycle; AES-256 alternates RotWord+Rcon and SubWord steps
    always_comb begin
        oddStep = (KEY_BITS == 256) && kIdx[0];
        w3      = lastRk[31:0];
        subIn   = oddStep ? w3 : {w3[23:0], w3[31:24]};
        subOut  = {sbox(subIn[31:24]), sbox(subIn[23:16]), sbox(subIn[15:8]), sbox(subIn[7:0])};
        rconIdx = (KEY_BITS == 256) ? (kIdx >> 1) : kIdx;
        temp    = subOut ^ (oddStep ? 32'h0 : {rconOf(rconIdx), 24'h0});
        base    = (KEY_BITS == 256) ? last2Rk : lastRk;
        n0      = base[127:96] ^ temp;
        n1      = base[95:64]  ^ n0;
        n2      = base[63:32]  ^ n1;
        n3      = base[31:0]   ^ n2;
        newRk   = {n0, n1, n2, n3};
    end

    always_comb begin
        stateD     = stateQ;
        keyLoadedD = keyLoadedQ;
        case (stateQ)
            IDLE: begin
                if (keyAcc) begin
                    stateD     = KEXP;
                    keyLoadedD = 1'b0;
                end else if (dataAcc) begin
                    stateD = INIT;
                end
            end
            KEXP: begin
                if (kIdx == IDX_W'(NR)) begin
                    stateD     = IDLE;
                    keyLoadedD = 1'b1;
                end
            end
            INIT:    stateD = RUN;
            RUN:     if (rnd == IDX_W'(UNROLL - 1)) stateD = DONE;
            DONE:    if (out_ready) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    // Round-key table survives reset; only key_loaded says whether it is usable
    always_ff @(posedge CLK) begin
        if (keyAcc) begin
            rkTable[0] <= key0;
            rkTable[1] <= key1;
        end else if (stateQ == KEXP) begin
            rkTable[kIdx] <= newRk;
        end
    end

    assign stage[0] = blk;
    for (genvar g = 0; g < UNROLL; g++) begin : gRound
        logic [IDX_W-1:0] rIdx;
        assign rIdx = rnd - IDX_W'(g);
        aes_inv_round uRound (
            .stateIn   (stage[g]),
            .roundKey  (rkTable[rIdx]),
            .finalRound(rIdx == '0),
            .stateOut  (stage[g+1])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_ready  <= 1'b1;
            keyLoadedQ <= 1'b0;
            inRdyQ     <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            kIdx       <= '0;
            rnd        <= '0;
            lastRk     <= '0;
            last2Rk    <= '0;
            blk        <= '0;
            cSaved     <= '0;
            cbcFlag    <= 1'b0;
            chain      <= '0;
        end else begin
            key_ready  <= (stateD == IDLE);
            keyLoadedQ <= keyLoadedD;
            inRdyQ     <= (stateD == IDLE) && keyLoadedD;
            out_valid  <= (stateD == DONE);

            if (keyAcc) begin
                lastRk  <= (KEY_BITS == 256) ? key1 : key0;
                last2Rk <= key0;
                kIdx    <= IDX_W'((KEY_BITS == 256) ? 2 : 1);
            end else if (stateQ == KEXP) begin
                last2Rk <= lastRk;
                lastRk  <= newRk;
                kIdx    <= kIdx + IDX_W'(1);
            end

            if (dataAcc) begin
                cSaved  <= data_in;
                cbcFlag <= (CBC_EN != 0) && cbc_mode;
            end

            if (stateQ == INIT) begin
                blk <= cSaved ^ rkTable[NR];
                rnd <= IDX_W'(NR - 1);
            end else if (stateQ == RUN) begin
                blk <= stage[UNROLL];
                rnd <= rnd - IDX_W'(UNROLL);
            end

            if (stateQ == RUN && stateD == DONE)
                data_out <= stage[UNROLL] ^ (cbcFlag ? chain : 128'h0);

            if (stateQ == IDLE && iv_load)
                chain <= iv_in;
            else if (stateQ == DONE && out_ready && cbcFlag)
                chain <= cSaved;
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench: four cores (128/256 x 1/2 rounds per clock) decrypt known-answer
// vectors; a per-core monitor checks plaintext and accept-to-valid latency.
module tb_aes_decrypt_iter;

    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_CBC = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV_CBC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_B1   = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] PT_B1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_B2   = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] PT_B2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic         keyValid [4];
    logic         keyReady [4];
    logic [255:0] keyIn    [4];
    logic         ivLoad   [4];
    logic [127:0] ivIn     [4];
    logic         cbcMode  [4];
    logic         inValid  [4];
    logic         inReady  [4];
    logic [127:0] dataIn   [4];
    logic         outValid [4];
    logic         outReady [4];
    logic [127:0] dataOut  [4];
    logic         keyLoaded[4];

    logic [127:0] expQ [4][$];
    int           accQ [4][$];
    logic         seen [4];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    function automatic int latOf(input int i);
        case (i)
            0:       return 11;
            1:       return 6;
            2:       return 15;
            default: return 8;
        endcase
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : gDut
        localparam int unsigned KB = (gi >= 2) ? 256 : 128;
        localparam int unsigned UN = (gi % 2 == 1) ? 2 : 1;

        aes_decrypt_iter #(.KEY_BITS(KB), .UNROLL(UN), .CBC_EN(1)) dut (
            .CLK       (clk),
            .RST_N     (rstN),
            .key_valid (keyValid[gi]),
            .key_ready (keyReady[gi]),
            .key_in    (keyIn[gi][KB-1:0]),
            .iv_load   (ivLoad[gi]),
            .iv_in     (ivIn[gi]),
            .cbc_mode  (cbcMode[gi]),
            .in_valid  (inValid[gi]),
            .in_ready  (inReady[gi]),
            .data_in   (dataIn[gi]),
            .out_valid (outValid[gi]),
            .out_ready (outReady[gi]),
            .data_out  (dataOut[gi]),
            .key_loaded(keyLoaded[gi])
        );

        // First cycle of each out_valid pulse is scored once
        always @(negedge clk) begin
            if (rstN && outValid[gi] && !seen[gi]) begin
                seen[gi] = 1'b1;
                if (expQ[gi].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dut%0d_unexpected: got %h want none", gi, dataOut[gi]);
                end else begin
                    logic [127:0] e;
                    int t;
                    e = expQ[gi].pop_front();
                    t = accQ[gi].pop_front();
                    check($sformatf("dut%0d_data", gi), dataOut[gi], e);
                    check($sformatf("dut%0d_latency", gi), 128'(cyc - t), 128'(latOf(gi)));
                end
            end
            if (outValid[gi] && outReady[gi]) seen[gi] = 1'b0;
        end
    end

    task automatic loadKey(input int i, input logic [255:0] key);
        int n;
        @(posedge clk); #1;
        keyValid[i] = 1'b1;
        keyIn[i]    = key;
        n = 0;
        @(negedge clk);
        while (!keyReady[i] && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) tmo("key_ready");
        @(posedge clk); #1;
        keyValid[i] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!keyLoaded[i] && n < 100) begin @(negedge clk); n++; end
        check($sformatf("dut%0d_key_loaded", i), 128'(keyLoaded[i]), 128'(1));
    endtask

    task automatic sendBlock(input int i, input logic [127:0] ct, input logic [127:0] pt,
                             input logic cbc, input logic withIv, input logic [127:0] iv);
        int n;
        @(posedge clk); #1;
        inValid[i] = 1'b1;
        dataIn[i]  = ct;
        cbcMode[i] = cbc;
        if (withIv) begin
            ivLoad[i] = 1'b1;
            ivIn[i]   = iv;
        end
        n = 0;
        @(negedge clk);
        while (!inReady[i] && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            tmo("in_ready");
            inValid[i] = 1'b0;
            ivLoad[i]  = 1'b0;
            return;
        end
        expQ[i].push_back(pt);
        @(posedge clk); #1;
        accQ[i].push_back(cyc);
        inValid[i] = 1'b0;
        ivLoad[i]  = 1'b0;
    endtask

    task automatic waitIdle(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!inReady[i] && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) tmo("idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            keyValid[i] = 1'b0; keyIn[i] = '0; ivLoad[i] = 1'b0; ivIn[i] = '0;
            cbcMode[i] = 1'b0; inValid[i] = 1'b0; dataIn[i] = '0; outReady[i] = 1'b1;
            seen[i] = 1'b0;
        end
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("rst_key_ready",  128'(keyReady[0]),  128'(1));
        check("rst_in_ready",   128'(inReady[0]),   128'(0));
        check("rst_out_valid",  128'(outValid[0]),  128'(0));
        check("rst_key_loaded", 128'(keyLoaded[0]), 128'(0));
        check("rst_data_out",   dataOut[0],         128'(0));

        // FIPS-197 C.1 / C.3 on every geometry
        for (int i = 0; i < 4; i++) begin
            loadKey(i, (i < 2) ? 256'(KEY_C1) : KEY_C3);
            sendBlock(i, (i < 2) ? CT_C1 : CT_C3, PT_FIPS, 1'b0, 1'b0, '0);
            waitIdle(i);
        end

        // CBC chain, IV loaded in the same cycle as the first block
        loadKey(0, 256'(KEY_CBC));
        sendBlock(0, CT_B1, PT_B1, 1'b1, 1'b1, IV_CBC);
        waitIdle(0);
        sendBlock(0, CT_B2, PT_B2, 1'b1, 1'b0, '0);
        waitIdle(0);

        // Backpressure hold
        loadKey(0, 256'(KEY_C1));
        @(posedge clk); #1;
        outReady[0] = 1'b0;
        sendBlock(0, CT_C1, PT_FIPS, 1'b0, 1'b0, '0);
        n = 0;
        @(negedge clk);
        while (!outValid[0] && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) tmo("bp_out_valid");
        for (int k = 0; k < 20; k++) begin
            check("bp_data",  dataOut[0], PT_FIPS);
            check("bp_flags", 128'({outValid[0], inReady[0]}), 128'(2'b10));
            @(negedge clk);
        end
        @(posedge clk); #1;
        outReady[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release", 128'({outValid[0], inReady[0]}), 128'(2'b01));

        // Reset during RUN aborts the block
        sendBlock(0, CT_C1, PT_FIPS, 1'b0, 1'b0, '0);
        repeat (4) @(posedge clk);
        #2;
        rstN = 1'b0;
        expQ[0].delete();
        accQ[0].delete();
        seen[0] = 1'b0;
        @(negedge clk);
        check("rstrun_out_valid",  128'(outValid[0]),  128'(0));
        check("rstrun_key_loaded", 128'(keyLoaded[0]), 128'(0));
        check("rstrun_in_ready",   128'(inReady[0]),   128'(0));
        @(negedge clk);
        rstN = 1'b1;
        loadKey(0, 256'(KEY_C1));
        sendBlock(0, CT_C1, PT_FIPS, 1'b0, 1'b0, '0);
        waitIdle(0);

        // Key load wins over a simultaneous block
        @(posedge clk); #1;
        keyValid[0] = 1'b1;
        keyIn[0]    = 256'(KEY_C1);
        inValid[0]  = 1'b1;
        dataIn[0]   = CT_C1;
        cbcMode[0]  = 1'b0;
        @(negedge clk);
        check("simul_in_ready",  128'(inReady[0]),  128'(0));
        check("simul_key_ready", 128'(keyReady[0]), 128'(1));
        @(posedge clk); #1;
        keyValid[0] = 1'b0;
        @(negedge clk);
        check("simul_kexp", 128'({keyLoaded[0], inReady[0], keyReady[0]}), 128'(3'b000));
        n = 0;
        while (!inReady[0] && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) tmo("simul_in_ready_wait");
        expQ[0].push_back(PT_FIPS);
        @(posedge clk); #1;
        accQ[0].push_back(cyc);
        inValid[0] = 1'b0;
        waitIdle(0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty",
              128'(expQ[0].size() + expQ[1].size() + expQ[2].size() + expQ[3].size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
